// File: rtl/if_fetch.sv
// if_fetch : instruction-fetch stage of the 5-stage MIPS pipeline.
//
// Owns the PC register and drives a synchronous instruction SRAM that has a
// 1-cycle read latency. It produces the IF->ID bus {ce, pc}. It also produces
// a stall-safe instruction word. While ID is frozen, that word keeps showing
// ID's instruction, even though the SRAM keeps re-reading the stalled IF
// address.
//
// Ports
//   clk             pipeline clock; all state changes on posedge
//   rst             asynchronous, active-high reset
//   stall[5:0]      stall vector from ctrl (1 = stop):
//                     [0] = PC/IF, [1] = ID, [2] = EX
//   br_bus[32:0]    {br_e, br_addr}; combinational redirect from ID
//   if_to_id_bus    {ce_reg, pc_reg}
//   inst_to_id      instruction word for the instruction currently in ID
//   inst_sram_*     instruction SRAM port (read-only use; en = ce_reg, addr = pc_reg)
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hbfbf_fffc
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [32:0] br_bus,
  output logic [32:0] if_to_id_bus,
  output logic [31:0] inst_to_id,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic        br_e;
  logic [31:0] br_addr;
  logic [31:0] pc_reg;
  logic        ce_reg;
  logic        br_pend;
  logic [31:0] br_pend_addr;
  logic        buf_valid;
  logic [31:0] inst_buf;
  logic [31:0] next_pc;
  logic        unused_stall_hi;

  assign br_e    = br_bus[32];
  assign br_addr = br_bus[31:0];

  // Only the IF, ID and EX stall bits are relevant to this stage.
  assign unused_stall_hi = ^stall[5:3];

  // A live branch wins over a redirect that was latched during a stall.
  always_comb begin
    next_pc = pc_reg + 32'd4;
    if (br_e) begin
      next_pc = br_addr;
    end else if (br_pend) begin
      next_pc = br_pend_addr;
    end
  end

  // PC register and pending-branch latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg       <= RESET_PC;
      ce_reg       <= 1'b0;
      br_pend      <= 1'b0;
      br_pend_addr <= 32'h0;
    end else if (!stall[0]) begin
      pc_reg  <= next_pc;
      ce_reg  <= 1'b1;
      br_pend <= 1'b0;
    end else if (br_e) begin
      // ID resolves the branch while IF is frozen. Remember the target so
      // that it is not lost. A later branch in the same stall overwrites it.
      br_pend      <= 1'b1;
      br_pend_addr <= br_addr;
    end
  end

  // Instruction hold buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      inst_buf  <= 32'h0;
    end else if (!stall[1]) begin
      // ID takes {ce_reg, pc_reg} on this edge. Next cycle's rdata belongs to it.
      buf_valid <= 1'b0;
    end else if (!stall[2]) begin
      // ID turns into a bubble, so it must see a nop.
      buf_valid <= 1'b1;
      inst_buf  <= 32'h0;
    end else if (!buf_valid) begin
      // ID is frozen. From now on the SRAM re-reads the stalled IF address,
      // so keep the word that ID is currently decoding.
      buf_valid <= 1'b1;
      inst_buf  <= inst_sram_rdata;
    end
  end

  assign if_to_id_bus    = {ce_reg, pc_reg};
  assign inst_sram_en    = ce_reg;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_addr  = pc_reg;
  assign inst_sram_wdata = 32'h0;

  // While reset is asserted, rdata is whatever the SRAM last held. Force a
  // clean zero instead.
  always_comb begin
    if (rst) begin
      inst_to_id = 32'h0;
    end else if (buf_valid) begin
      inst_to_id = inst_buf;
    end else begin
      inst_to_id = inst_sram_rdata;
    end
  end

endmodule
